// File: rtl/writeback_regfile_if.sv
// Shared types and the memory-stage -> writeback bus.
//
// writeback_regfile_pkg : data types used on the writeback side
//   UIntX  - integer register value (32 bits)
//   InstPc - instruction address (32 bits)
//   IId    - instruction id (8 bits)
//   FwCtrl - writeback forwarding record {valid, can_forward, addr, wdata}
//
// writeback_regfile_if  : one completed instruction per cycle from the
// memory stage, plus the trap/flush kill.
//   master - driven by the memory stage / trap logic
//   slave  - consumed by writeback_regfile
package writeback_regfile_pkg;
  typedef logic [31:0] UIntX;
  typedef logic [31:0] InstPc;
  typedef logic [7:0]  IId;

  typedef struct packed {
    logic       valid;
    logic       can_forward;
    logic [4:0] addr;
    UIntX       wdata;
  } FwCtrl;
endpackage

interface writeback_regfile_if;
  import writeback_regfile_pkg::*;

  logic       mem_wb_valid;
  InstPc      mem_wb_pc;
  IId         mem_wb_inst_id;
  logic       mem_wb_rf_wen;
  logic [4:0] mem_wb_addr;
  UIntX       mem_wb_wdata;
  logic       wb_kill;

  modport master (
    output mem_wb_valid, mem_wb_pc, mem_wb_inst_id, mem_wb_rf_wen,
           mem_wb_addr, mem_wb_wdata, wb_kill
  );

  modport slave (
    input  mem_wb_valid, mem_wb_pc, mem_wb_inst_id, mem_wb_rf_wen,
           mem_wb_addr, mem_wb_wdata, wb_kill
  );
endinterface

// File: rtl/writeback_regfile.sv
// Final pipeline stage and owner of the 32-entry architectural register file.
// An instruction from the memory stage is latched into a one-entry stage
// register, then commits into the register file at the following edge.
// While it sits in the stage register it is visible on the forwarding record
// so consumers never see a gap between capture and regfile update.
//
// Optional feature macro: WB_RETIRE_COUNTER_EN adds output wb_retire_count
// (wrapping count of committed instructions, RETIRE_W bits wide).
//
// Ports:
//   clk               clock
//   reset             synchronous, active-high reset
//   mem_wb            memory-stage bus (slave side)
//   regfile           architectural registers, entry 0 hard-wired to 0
//   dh_wb_fw          forwarding record for the instruction now committing
//   wb_retire_valid   pulses in the cycle an instruction commits
//   wb_retire_inst_id id of the committing instruction
//   wb_retire_pc      PC of the committing instruction
//   wb_retire_count   committed-instruction count (macro only)
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned RETIRE_W = 64
)
(
  input  logic                  clk,
  input  logic                  reset,
  writeback_regfile_if.slave    mem_wb,
  output UIntX [31:0]           regfile,
  output FwCtrl                 dh_wb_fw,
`ifdef WB_RETIRE_COUNTER_EN
  output logic [RETIRE_W-1:0]   wb_retire_count,
`endif
  output logic                  wb_retire_valid,
  output IId                    wb_retire_inst_id,
  output InstPc                 wb_retire_pc
);

  typedef struct packed {
    logic       v;
    InstPc      pc;
    IId         inst_id;
    logic       rf_wen;
    logic [4:0] addr;
    UIntX       wdata;
  } stage_t;

  stage_t      s_d, s_q;
  // Entry 0 has no storage; it is spliced in as a constant below.
  UIntX [31:1] rf_q;
  logic        commit_wr;

  // Payload loads every cycle; only the valid bit is qualified by the kill.
  always_comb begin
    s_d         = '0;
    s_d.v       = mem_wb.mem_wb_valid && !mem_wb.wb_kill;
    s_d.pc      = mem_wb.mem_wb_pc;
    s_d.inst_id = mem_wb.mem_wb_inst_id;
    s_d.rf_wen  = mem_wb.mem_wb_rf_wen;
    s_d.addr    = mem_wb.mem_wb_addr;
    s_d.wdata   = mem_wb.mem_wb_wdata;
  end

  assign commit_wr = s_q.v && s_q.rf_wen && (s_q.addr != 5'd0);

  // Reset takes priority, so a commit pending in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q  <= '0;
      // NOTE: the register file is reset explicitly because software relies
      // on all registers reading 0 after reset; this forces flops, not RAM.
      rf_q <= '0;
    end else begin
      // NOTE: non-blocking updates let the commit read the old s_q while
      // s_q is overwritten with the next instruction at the same edge.
      s_q <= s_d;
      if (commit_wr) rf_q[s_q.addr] <= s_q.wdata;
    end
  end

  assign regfile = {rf_q, UIntX'(0)};

  // Writeback data is final, so anything valid here can always forward.
  always_comb begin
    dh_wb_fw = '0;
    if (commit_wr) begin
      dh_wb_fw.valid       = 1'b1;
      dh_wb_fw.can_forward = 1'b1;
      dh_wb_fw.addr        = s_q.addr;
      dh_wb_fw.wdata       = s_q.wdata;
    end
  end

  // Every instruction in the stage retires, writing or not.
  assign wb_retire_valid   = s_q.v;
  assign wb_retire_inst_id = s_q.inst_id;
  assign wb_retire_pc      = s_q.pc;

`ifdef WB_RETIRE_COUNTER_EN
  logic [RETIRE_W-1:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)      retire_cnt_q <= '0;
    else if (s_q.v) retire_cnt_q <= retire_cnt_q + 1'b1;
  end

  assign wb_retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: the driver pushes an expected
// retire record for every accepted instruction; the monitor pops one per
// observed commit cycle and also keeps an architectural register array and
// retire count that are updated on each committed instruction.
module tb_writeback_regfile;
  import writeback_regfile_pkg::*;

  localparam int RW = 4;
`ifdef WB_RETIRE_COUNTER_EN
  logic [RW-1:0] wb_retire_count;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  UIntX [31:0] regfile;
  FwCtrl       dh_wb_fw;
  logic        wb_retire_valid;
  IId          wb_retire_inst_id;
  InstPc       wb_retire_pc;

  writeback_regfile_if bus ();

  writeback_regfile #(.RETIRE_W(RW)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_wb            (bus.slave),
    .regfile           (regfile),
    .dh_wb_fw          (dh_wb_fw),
`ifdef WB_RETIRE_COUNTER_EN
    .wb_retire_count   (wb_retire_count),
`endif
    .wb_retire_valid   (wb_retire_valid),
    .wb_retire_inst_id (wb_retire_inst_id),
    .wb_retire_pc      (wb_retire_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    InstPc      pc;
    IId         id;
    logic       wen;
    logic [4:0] addr;
    UIntX       wdata;
  } item_t;

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at negedge, record acceptance at posedge.
  task automatic issue(input bit v, input bit wen, input logic [4:0] a,
                       input logic [31:0] d, input bit kill = 0, input bit rst = 0);
    item_t it;
    @(negedge clk);
    reset              = rst;
    bus.mem_wb_valid   = v;
    bus.mem_wb_rf_wen  = wen;
    bus.mem_wb_addr    = a;
    bus.mem_wb_wdata   = d;
    bus.mem_wb_pc      = $urandom;
    bus.mem_wb_inst_id = IId'($urandom);
    bus.wb_kill        = kill;
    it.pc = bus.mem_wb_pc; it.id = bus.mem_wb_inst_id;
    it.wen = wen; it.addr = a; it.wdata = d;
    @(posedge clk);
    if (!rst && v && !kill) exp_q.push_back(it);
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) issue(0, 0, 5'd0, 32'd0);
  endtask

  // Monitor / reference model.
  initial begin : monitor
    UIntX  model_rf [32];
    item_t pend;
    bit    pend_v;
    int    m_cnt;
    FwCtrl exp_fw;
    bit    exp_ret;
    pend_v = 0;
    m_cnt  = 0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        m_cnt = 0;
      end else if (pend_v) begin
        if (pend.wen && pend.addr != 0) model_rf[pend.addr] = pend.wdata;
        m_cnt++;
      end
      pend_v = 0;

      @(negedge clk);
      for (int i = 0; i < 32; i++)
        check($sformatf("regfile[%0d]", i), 64'(regfile[i]), 64'(model_rf[i]));
`ifdef WB_RETIRE_COUNTER_EN
      check("retire_count", 64'(wb_retire_count), 64'(m_cnt % (1 << RW)));
`endif
      exp_ret = (exp_q.size() != 0);
      check("retire_valid", 64'(wb_retire_valid), 64'(exp_ret));
      exp_fw = '0;
      if (exp_ret) begin
        pend   = exp_q.pop_front();
        pend_v = 1;
        check("retire_id", 64'(wb_retire_inst_id), 64'(pend.id));
        check("retire_pc", 64'(wb_retire_pc), 64'(pend.pc));
        if (pend.wen && pend.addr != 0) begin
          exp_fw.valid = 1; exp_fw.can_forward = 1;
          exp_fw.addr = pend.addr; exp_fw.wdata = pend.wdata;
        end
      end
      check("dh_wb_fw", 64'(dh_wb_fw), 64'(exp_fw));
    end
  end

  initial begin : driver
    bus.mem_wb_valid = 0; bus.mem_wb_rf_wen = 0; bus.mem_wb_addr = 0;
    bus.mem_wb_wdata = 0; bus.mem_wb_pc = 0; bus.mem_wb_inst_id = 0;
    bus.wb_kill = 0;
    issue(0, 0, 5'd0, 32'd0, 0, 1);
    issue(0, 0, 5'd0, 32'd0, 0, 1);
    idle(2);
    // Single write, then write to x0.
    issue(1, 1, 5'd5, 32'hDEADBEEF); idle(2);
    issue(1, 1, 5'd0, 32'd1);        idle(2);
    // Back-to-back writes to x7.
    issue(1, 1, 5'd7, 32'd1); issue(1, 1, 5'd7, 32'd2); idle(2);
    // Kill with an older instruction already in the stage.
    issue(1, 1, 5'd8, 32'h11); issue(1, 1, 5'd3, 32'd9, 1); idle(2);
    // Reset in the commit cycle.
    issue(1, 1, 5'd4, 32'd5); issue(0, 0, 5'd0, 32'd0, 0, 1); idle(2);
    // Seventeen retires from reset (count wraps with a 4-bit counter).
    issue(0, 0, 5'd0, 32'd0, 0, 1);
    for (int i = 0; i < 17; i++) issue(1, 1'($urandom), 5'($urandom), $urandom);
    idle(2);
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom),
            $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
